// File: rtl/lane_add_sequencer.sv
// lane_add_sequencer: one shared W-bit adder walks N operand lanes, one lane
// per output transfer, streaming each sum over valid/ready and assembling the
// full result vector in z / z_carry.
module lane_add_sequencer #(
    parameter int N = 5,
    parameter int W = 8,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_valid,
    output logic           start_ready,
    input  logic           dir,
    input  logic [N*W-1:0] x,
    input  logic [N*W-1:0] y,
    input  logic           abort,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [IW-1:0]  out_idx,
    output logic [W-1:0]   out_sum,
    output logic           out_carry,
    output logic           out_last,
    output logic [N*W-1:0] z,
    output logic [N-1:0]   z_carry,
    output logic           done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [IW-1:0] idx_reg;
    logic          dir_reg;
    logic          done_reg;
    logic [W-1:0]  x_reg [N];
    logic [W-1:0]  y_reg [N];
    logic [W-1:0]  z_reg [N];
    logic          z_carry_reg [N];

    logic          start_acc;
    logic          in_run;
    logic          lane_last;
    logic          commit;
    logic [W:0]    lane_sum;

    assign start_acc = (state_reg == IDLE) && start_valid;
    assign in_run    = (state_reg == RUN);
    // The final lane depends on the walk direction latched at start.
    assign lane_last = dir_reg ? (idx_reg == '0) : (idx_reg == IW'(N - 1));
    // abort wins over a simultaneous transfer: nothing is committed that cycle.
    assign commit    = in_run && out_ready && !abort;
    assign lane_sum  = {1'b0, x_reg[idx_reg]} + {1'b0, y_reg[idx_reg]};

    assign start_ready = (state_reg == IDLE);
    assign out_valid   = in_run;
    assign out_idx     = idx_reg;
    assign out_sum     = lane_sum[W-1:0];
    assign out_carry   = lane_sum[W];
    assign out_last    = in_run && lane_last;
    assign done        = done_reg;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; out_ready only affects the state, never out_valid directly.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start_valid) state_next = RUN;
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (out_ready && lane_last) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Lane index: loaded at start, stepped on every committed non-final transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_reg <= '0;
            dir_reg <= 1'b0;
        end else if (start_acc) begin
            dir_reg <= dir;
            idx_reg <= dir ? IW'(N - 1) : '0;
        end else if (commit && !lane_last) begin
            idx_reg <= dir_reg ? (idx_reg - IW'(1)) : (idx_reg + IW'(1));
        end
    end

    // Operand capture at start accept; later changes on x/y are ignored.
    always_ff @(posedge clk) begin
        if (start_acc) begin
            for (int i = 0; i < N; i++) begin
                x_reg[i] <= x[i*W +: W];
                y_reg[i] <= y[i*W +: W];
            end
        end
    end

    // Result assembly: cleared at start, one lane written per committed transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                z_reg[i]       <= '0;
                z_carry_reg[i] <= 1'b0;
            end
        end else if (start_acc) begin
            for (int i = 0; i < N; i++) begin
                z_reg[i]       <= '0;
                z_carry_reg[i] <= 1'b0;
            end
        end else if (commit) begin
            z_reg[idx_reg]       <= lane_sum[W-1:0];
            z_carry_reg[idx_reg] <= lane_sum[W];
        end
    end

    // done is high for the single DONE cycle that follows the final transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_reg <= 1'b0;
        end else begin
            done_reg <= commit && lane_last;
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_pack
            assign z[gi*W +: W] = z_reg[gi];
            assign z_carry[gi]  = z_carry_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_lane_add_sequencer.sv
// Directed and randomized jobs for lane_add_sequencer (N=5 and N=1 builds),
// checked against a lane-by-lane arithmetic reference.
module tb_lane_add_sequencer;

    localparam int N = 5;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // N=5 build
    logic           start_valid = 0, dir = 0, abort = 0, out_ready = 0;
    logic [N*W-1:0] x = '0, y = '0;
    logic           start_ready, out_valid, out_carry, out_last, done;
    logic [2:0]     out_idx;
    logic [W-1:0]   out_sum;
    logic [N*W-1:0] z;
    logic [N-1:0]   z_carry;

    // N=1 build
    logic           start_valid1 = 0, dir1 = 0, abort1 = 0, out_ready1 = 0;
    logic [W-1:0]   x1 = '0, y1 = '0;
    logic           start_ready1, out_valid1, out_carry1, out_last1, done1;
    logic [0:0]     out_idx1;
    logic [W-1:0]   out_sum1;
    logic [W-1:0]   z1;
    logic [0:0]     z_carry1;

    lane_add_sequencer #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
        .dir(dir), .x(x), .y(y), .abort(abort), .out_valid(out_valid),
        .out_ready(out_ready), .out_idx(out_idx), .out_sum(out_sum),
        .out_carry(out_carry), .out_last(out_last), .z(z), .z_carry(z_carry),
        .done(done)
    );

    lane_add_sequencer #(.N(1), .W(W)) dut1 (
        .clk(clk), .rst(rst), .start_valid(start_valid1), .start_ready(start_ready1),
        .dir(dir1), .x(x1), .y(y1), .abort(abort1), .out_valid(out_valid1),
        .out_ready(out_ready1), .out_idx(out_idx1), .out_sum(out_sum1),
        .out_carry(out_carry1), .out_last(out_last1), .z(z1), .z_carry(z_carry1),
        .done(done1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One job on the N=5 build. Lanes are taken in walk order k=0..N-1;
    // stall_len cycles of out_ready=0 precede transfer k==stall_at, and
    // abort is raised together with transfer k==abort_at (-1 = none).
    task automatic run_job(input logic [N*W-1:0] xv, input logic [N*W-1:0] yv,
                           input logic d, input int stall_at, input int stall_len,
                           input int abort_at, input string name);
        int exp_z [N];
        int exp_c [N];
        logic [N*W-1:0] ez;
        logic [N-1:0]   ezc;
        int lane, s, cyc, waited;
        bit aborted;
        for (int i = 0; i < N; i++) begin
            exp_z[i] = 0;
            exp_c[i] = 0;
        end
        waited = 0;
        while (!start_ready && waited < 20) begin
            step();
            waited++;
        end
        chk({name, "_start_ready"}, start_ready, 1'b1);
        start_valid = 1; x = xv; y = yv; dir = d; out_ready = 1;
        step();
        start_valid = 0;
        cyc = 1;
        chk({name, "_z_cleared"}, {24'd0, z}, {24'd0, 40'd0});
        aborted = 0;
        for (int k = 0; k < N && !aborted; k++) begin
            lane = d ? (N - 1 - k) : k;
            s = int'(xv[lane*W +: W]) + int'(yv[lane*W +: W]);
            if (k == stall_at) begin
                for (int c = 0; c < stall_len; c++) begin
                    out_ready = 0;
                    x = 40'({$urandom(), $urandom()});
                    dir = ~d;
                    chk({name, "_stall_valid"}, out_valid, 1'b1);
                    chk({name, "_stall_idx"}, out_idx, lane);
                    chk({name, "_stall_sum"}, out_sum, s % 256);
                    step();
                    cyc++;
                end
            end
            out_ready = 1;
            y = 40'({$urandom(), $urandom()});
            chk({name, "_valid"}, out_valid, 1'b1);
            chk({name, "_idx"}, out_idx, lane);
            chk({name, "_sum"}, out_sum, s % 256);
            chk({name, "_carry"}, out_carry, (s >= 256));
            chk({name, "_last"}, out_last, (k == N - 1));
            if (k == abort_at) begin
                abort = 1;
                aborted = 1;
            end else begin
                exp_z[lane] = s % 256;
                exp_c[lane] = (s >= 256) ? 1 : 0;
            end
            step();
            cyc++;
            abort = 0;
        end
        ez = '0; ezc = '0;
        for (int i = 0; i < N; i++) begin
            ez[i*W +: W] = W'(exp_z[i]);
            ezc[i] = exp_c[i][0];
        end
        if (aborted) begin
            chk({name, "_abort_done"}, done, 1'b0);
            chk({name, "_abort_ready"}, start_ready, 1'b1);
            chk({name, "_abort_valid"}, out_valid, 1'b0);
        end else begin
            chk({name, "_done"}, done, 1'b1);
            chk({name, "_done_latency"}, cyc, N + 1 + ((stall_at >= 0) ? stall_len : 0));
            chk({name, "_done_ready"}, start_ready, 1'b0);
        end
        chk({name, "_z"}, {24'd0, z}, {24'd0, ez});
        chk({name, "_z_carry"}, z_carry, ezc);
        step();
        chk({name, "_done_clear"}, done, 1'b0);
        chk({name, "_ready_again"}, start_ready, 1'b1);
        $display("job %s dir=%0d stall_at=%0d abort_at=%0d z=%h z_carry=%b", name, d, stall_at, abort_at, z, z_carry);
    endtask

    initial begin
        logic [N*W-1:0] tx, ty;
        int n_xfer, n_done, last_xfer, s1;

        // Reset values
        #2;
        chk("rst_start_ready", start_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_done", done, 1'b0);
        chk("rst_z", {24'd0, z}, 64'd0);
        chk("rst_z_carry", z_carry, 5'd0);
        step();
        rst = 0;
        step();

        tx = {8'd250, 8'd4, 8'd3, 8'd2, 8'd1};
        ty = {8'd10, 8'd1, 8'd1, 8'd1, 8'd1};
        run_job(tx, ty, 1'b0, -1, 0, -1, "asc");
        chk("asc_zc_plan", z_carry, 5'b10000);
        chk("asc_z_plan", {24'd0, z}, {24'd0, 8'd4, 8'd5, 8'd4, 8'd3, 8'd2});
        run_job(tx, ty, 1'b1, -1, 0, -1, "desc");
        chk("desc_z_plan", {24'd0, z}, {24'd0, 8'd4, 8'd5, 8'd4, 8'd3, 8'd2});
        run_job(tx, ty, 1'b0, 2, 3, -1, "bp");
        run_job(tx, ty, 1'b0, -1, 0, 2, "abort");

        for (int j = 0; j < 8; j++) begin
            run_job(40'({$urandom(), $urandom()}), 40'({$urandom(), $urandom()}),
                    1'($urandom_range(0, 1)), $urandom_range(0, N - 1),
                    $urandom_range(0, 3), (j % 4 == 3) ? $urandom_range(0, N - 1) : -1,
                    $sformatf("rnd%0d", j));
        end

        // Asynchronous reset between edges, in the middle of a descending job
        start_valid = 1; x = tx; y = ty; dir = 1; out_ready = 1;
        step();
        start_valid = 0;
        step();
        step();
        #2 rst = 1;
        #1;
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_ready", start_ready, 1'b1);
        chk("arst_idx", out_idx, 0);
        chk("arst_last", out_last, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_z", {24'd0, z}, 64'd0);
        #1 rst = 0;
        step();
        chk("arst_after_done", done, 1'b0);
        run_job(tx, ty, 1'b0, -1, 0, -1, "post_rst");

        // N=1 build: start_valid held high, jobs every 3 cycles
        x1 = 8'($urandom()); y1 = 8'($urandom());
        s1 = int'(x1) + int'(y1);
        start_valid1 = 1; out_ready1 = 1;
        n_xfer = 0; n_done = 0; last_xfer = -10;
        for (int c = 0; c < 12; c++) begin
            step();
            if (out_valid1) begin
                if (n_xfer > 0) chk("n1_spacing", c - last_xfer, 3);
                last_xfer = c;
                n_xfer++;
                chk("n1_last", out_last1, 1'b1);
                chk("n1_idx", out_idx1, 1'b0);
                chk("n1_sum", {out_carry1, out_sum1}, 9'(s1));
                $display("n1 transfer cycle=%0d sum=%0d carry=%0d", c, out_sum1, out_carry1);
            end
            if (done1) begin
                n_done++;
                chk("n1_z", {z_carry1, z1}, 9'(s1));
            end
        end
        start_valid1 = 0;
        chk("n1_xfer_count", n_xfer, 4);
        chk("n1_done_count", n_done, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lane_add_sequencer.md
# lane_add_sequencer

- Time-multiplexes one shared W-bit adder across N lanes, computing z[i] = x[i] + y[i] one lane per transfer.
- Streams each lane result over a valid/ready output and assembles the full result vector.
- Lanes are walked in ascending (0..N-1) or descending (N-1..0) order, chosen per job.
- Replaces the per-lane generate-loop adder array where area matters more than throughput.

## Interface
Parameters:
- N, default 5: number of lanes, ≥1.
- W, default 8: lane width in bits, ≥1.
- IW, derived, not overridable: max(1, $clog2(N)), the index width.

Ports (clock and reset first):
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start_valid  in  1  job request.
- start_ready  out  1  high only in IDLE.
- dir  in  1  lane order, sampled on start accept: 0 ascending, 1 descending.
- x  in  N*W  operand lanes, lane i = x[i*W +: W], sampled on start accept.
- y  in  N*W  second operand lanes, same layout and sampling as x.
- abort  in  1  cancels the running job.
- out_valid  out  1  lane result available.
- out_ready  in  1  consumer accepts the lane result.
- out_idx  out  IW  lane index of the current result.
- out_sum  out  W  (x[idx] + y[idx]) mod 2^W.
- out_carry  out  1  carry-out of that addition.
- out_last  out  1  current lane is the final lane of the job.
- z  out  N*W  assembled sums.
- z_carry  out  N  per-lane carries.
- done  out  1  one-cycle pulse when a job completes.

## Operation
States:
- IDLE: start_ready=1.
  - On start_valid: latch x, y and dir.
  - Clear z and z_carry to 0.
  - Set idx to 0 if dir=0, else N-1.
  - Go to RUN.
- RUN: out_valid=1.
  - out_sum and out_carry come combinationally from the latched operands at idx.
  - On a transfer (out_valid && out_ready):
    - Write z[idx] and z_carry[idx].
    - If out_last, go to DONE.
    - Otherwise step idx by +1 (ascending) or -1 (descending).
  - Without out_ready: hold idx and all outputs stable.
- DONE: done=1 for exactly one cycle, then IDLE. start_ready=0 in DONE.

Rules:
- out_last = (idx == N-1) when ascending; (idx == 0) when descending.
- idx never wraps: ascending stops at N-1, descending stops at 0.
- Sum width is W+1; the low W bits go to out_sum, the MSB to out_carry.
- abort:
  - In RUN, go to IDLE next cycle with no done pulse.
  - abort beats a simultaneous transfer: z is not written that cycle.
  - Lanes already written remain in z.
  - abort is ignored in IDLE and DONE.
- N=1: idx is constant 0, and out_last=1 on the first lane.
- start_valid while not in IDLE is ignored; the requester holds it until start_ready.
- x, y and dir changing during RUN have no effect.

## Timing
- Reset values: state IDLE, idx 0, z 0, z_carry 0, done 0, out_valid 0, out_last 0, out_idx 0, start_ready 1.
- Registered outputs: z, z_carry, done.
- Combinational from state/registers: out_valid, out_idx, out_sum, out_carry, out_last, start_ready.
- No combinational path from out_ready to out_valid.
- Start accepted at edge T:
  - First lane valid in cycle T+1.
  - With out_ready held high, lane k transfers in cycle T+1+k.
  - done pulses in cycle T+N+1.
  - start_ready is high again in cycle T+N+2.
- Each cycle with out_ready low adds one cycle of latency.
- Reset asserted mid-job: immediate return to the reset values with no done pulse. Operation resumes on the first edge after deassertion.

## Test plan
- Ascending run: N=5, W=8, x lanes {1,2,3,4,250}, y lanes {1,1,1,1,10}, dir=0, out_ready=1.
  - out_idx sequence 0,1,2,3,4.
  - Sums 2,3,4,5,4; lane 4 carry=1.
  - out_last only on idx 4.
  - done at T+6; z_carry=5'b10000.
- Descending run, same operands, dir=1: out_idx 4,3,2,1,0; out_last on idx 0; final z identical to the ascending run.
- Backpressure: deassert out_ready for 3 cycles at idx 2. Outputs stay stable throughout, no lane is skipped or duplicated, and done is delayed by exactly 3 cycles.
- Abort at idx 2 together with out_ready=1: z lane 2 stays 0, lanes 0 and 1 are written, no done pulse, start_ready=1 next cycle.
- Asynchronous rst pulse mid-RUN, between clock edges: outputs drop to the reset values immediately, and a fresh start completes normally.
- N=1 build, with start_valid held high for multiple jobs: one transfer with out_last=1 per job, and back-to-back jobs accepted every 3 cycles.
